// File: rtl/serializador_palavra_pkg.sv
// Shared definitions for the word serializer: FSM encoding and counter sizing.
package serializador_palavra_pkg;

  localparam int unsigned LARGURA_PADRAO = 4;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    DESLOCANDO = 2'd1,
    FINAL      = 2'd2
  } estado_t;

  // Bit-index counter width; never narrower than one bit.
  function automatic int unsigned largura_contador(input int unsigned largura);
    return (largura < 2) ? 1 : $clog2(largura);
  endfunction

endpackage

// File: rtl/serializador_palavra_contador_bits.sv
// Bit-position counter: clears on load, counts up and saturates at LARGURA-1
// with a registered terminal flag.
module contador_bits
  import serializador_palavra_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_PADRAO
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  logic                                 carregar_i,
  input  logic                                 incrementar_i,
  output logic [largura_contador(LARGURA)-1:0] valor_o,
  output logic                                 ultimo_o
);

  localparam int unsigned CW = largura_contador(LARGURA);

  logic [CW-1:0] valor_q;
  logic [CW-1:0] valor_d;
  logic          ultimo_q;

  always_comb begin
    valor_d = valor_q + CW'(1);
  end

  // The terminal flag is computed from the next value so it lines up with valor_q.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      valor_q  <= '0;
      ultimo_q <= 1'b0;
    end else if (carregar_i) begin
      valor_q  <= '0;
      ultimo_q <= 1'b0;
    end else if (incrementar_i && !ultimo_q) begin
      valor_q  <= valor_d;
      ultimo_q <= (valor_d == CW'(LARGURA - 1));
    end
  end

  assign valor_o  = valor_q;
  assign ultimo_o = ultimo_q;

endmodule

// File: rtl/serializador_palavra.sv
// Parallel-to-serial stage: accepts a word on valid/ready and shifts it out one
// bit per clock with a strobe, then pulses palavraCompleta for one cycle.
module serializador_palavra
  import serializador_palavra_pkg::*;
#(
  parameter int unsigned LARGURA      = LARGURA_PADRAO,
  parameter bit          MSB_PRIMEIRO = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] dadoEntrada,
  input  logic               entradaValida,
  output logic               entradaPronta,
  output logic               novoBit,
  output logic               bitValido,
  output logic               palavraCompleta,
  output logic               ocupado
);

  localparam int unsigned CW = largura_contador(LARGURA);

  estado_t            estado_q;
  logic [LARGURA-1:0] buffer_q;
  logic [CW-1:0]      contador;
  logic [CW-1:0]      indice_d;
  logic               ultimo;
  logic               aceite;
  logic               incrementar;

  // Maps a transmission slot to the buffer bit according to the send order.
  function automatic logic bit_de(input logic [LARGURA-1:0] palavra,
                                  input logic [CW-1:0]      indice);
    logic [CW-1:0] pos;
    pos = MSB_PRIMEIRO ? (CW'(LARGURA - 1) - indice) : indice;
    return palavra[pos];
  endfunction

  assign entradaPronta = ~reset & ((estado_q == OCIOSO) | (estado_q == FINAL));
  assign aceite        = entradaValida & entradaPronta;
  assign incrementar   = (estado_q == DESLOCANDO) & ~ultimo;

  always_comb begin
    indice_d = contador + CW'(1);
  end

  contador_bits #(
    .LARGURA(LARGURA)
  ) u_contador (
    .clock_i      (clock),
    .reset_i      (reset),
    .carregar_i   (aceite),
    .incrementar_i(incrementar),
    .valor_o      (contador),
    .ultimo_o     (ultimo)
  );

  // Outputs are registered alongside the state so they always describe the current cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q        <= OCIOSO;
      buffer_q        <= '0;
      novoBit         <= 1'b0;
      bitValido       <= 1'b0;
      palavraCompleta <= 1'b0;
      ocupado         <= 1'b0;
    end else begin
      palavraCompleta <= 1'b0;
      case (estado_q)
        OCIOSO, FINAL: begin
          if (aceite) begin
            estado_q  <= DESLOCANDO;
            buffer_q  <= dadoEntrada;
            novoBit   <= bit_de(dadoEntrada, '0);
            bitValido <= 1'b1;
            ocupado   <= 1'b1;
          end else begin
            estado_q  <= OCIOSO;
            novoBit   <= 1'b0;
            bitValido <= 1'b0;
            ocupado   <= 1'b0;
          end
        end
        DESLOCANDO: begin
          if (ultimo) begin
            estado_q        <= FINAL;
            novoBit         <= 1'b0;
            bitValido       <= 1'b0;
            ocupado         <= 1'b0;
            palavraCompleta <= 1'b1;
          end else begin
            novoBit <= bit_de(buffer_q, indice_d);
          end
        end
        default: begin
          estado_q  <= OCIOSO;
          novoBit   <= 1'b0;
          bitValido <= 1'b0;
          ocupado   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializador_palavra.sv
// Bench for serializador_palavra: three configurations, expected bit streams
// derived arithmetically from each offered word.
module tb_serializador_palavra;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Instance A: LARGURA=4, MSB first
  logic [3:0] da;
  logic va, pa, nba, bva, pca, oa;
  // Instance L: LARGURA=4, LSB first
  logic [3:0] dl;
  logic vl, pl, nbl, bvl, pcl, ol;
  // Instance W: LARGURA=8, MSB first
  logic [7:0] dw;
  logic vw, pw, nbw, bvw, pcw, ow;

  int total = 0;
  int bad   = 0;

  serializador_palavra #(.LARGURA(4), .MSB_PRIMEIRO(1'b1)) u_a (
    .clock(clock), .reset(reset), .dadoEntrada(da), .entradaValida(va),
    .entradaPronta(pa), .novoBit(nba), .bitValido(bva),
    .palavraCompleta(pca), .ocupado(oa));

  serializador_palavra #(.LARGURA(4), .MSB_PRIMEIRO(1'b0)) u_l (
    .clock(clock), .reset(reset), .dadoEntrada(dl), .entradaValida(vl),
    .entradaPronta(pl), .novoBit(nbl), .bitValido(bvl),
    .palavraCompleta(pcl), .ocupado(ol));

  serializador_palavra #(.LARGURA(8), .MSB_PRIMEIRO(1'b1)) u_w (
    .clock(clock), .reset(reset), .dadoEntrada(dw), .entradaValida(vw),
    .entradaPronta(pw), .novoBit(nbw), .bitValido(bvw),
    .palavraCompleta(pcw), .ocupado(ow));

  // Downstream 4-stage shift register, stage1 = sr[0] (newest)
  logic [3:0] sr;
  always @(posedge clock) if (bva === 1'b1) sr <= {sr[2:0], nba};

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    da = '0; va = 0; dl = '0; vl = 0; dw = '0; vw = 0;
    reset = 1'b1;
    tick; tick;
    total++;
    if ({pa, nba, bva, pca, oa} !== 5'b0)
      begin bad++; $display("FAIL reset_a: got %b exp 00000", {pa, nba, bva, pca, oa}); end
    total++;
    if ({pl, nbl, bvl, pcl, ol, pw, nbw, bvw, pcw, ow} !== 10'b0)
      begin bad++; $display("FAIL reset_lw: got %b exp 0", {pl, nbl, bvl, pcl, ol, pw, nbw, bvw, pcw, ow}); end
    reset = 1'b0;
    #1;
    total++;
    if ({pa, pl, pw} !== 3'b111)
      begin bad++; $display("FAIL reset_release_ready: got %b exp 111", {pa, pl, pw}); end
    tick;
  endtask

  task automatic test_single_word;
    int w = 4'b1011;
    da = 4'(w); va = 1; tick;
    va = 0; da = 4'(~w);
    for (int i = 0; i < 4; i++) begin
      int e = (w >> (3 - i)) & 1;
      total++;
      if (bva !== 1'b1 || nba !== 1'(e) || pca !== 1'b0 || oa !== 1'b1 || pa !== 1'b0)
        begin bad++; $display("FAIL single_bit%0d: bv=%b nb=%b pc=%b oc=%b pr=%b exp bv=1 nb=%0d pc=0 oc=1 pr=0", i, bva, nba, pca, oa, pa, e); end
      tick;
    end
    total++;
    if (pca !== 1'b1 || bva !== 1'b0 || nba !== 1'b0 || pa !== 1'b1)
      begin bad++; $display("FAIL single_final: pc=%b bv=%b nb=%b pr=%b exp 1 0 0 1", pca, bva, nba, pa); end
    total++;
    if (sr !== 4'b1011)
      begin bad++; $display("FAIL single_stages: got %b exp 1011", sr); end
    tick;
    total++;
    if (pca !== 1'b0 || pa !== 1'b1 || oa !== 1'b0 || bva !== 1'b0)
      begin bad++; $display("FAIL single_idle: pc=%b pr=%b oc=%b bv=%b exp 0 1 0 0", pca, pa, oa, bva); end
  endtask

  task automatic test_lsb_first;
    for (int n = 0; n < 3; n++) begin
      int w = (n == 0) ? 4'b1000 : int'($urandom_range(0, 15));
      dl = 4'(w); vl = 1; tick;
      vl = 0; dl = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        int e = (w >> i) & 1;
        total++;
        if (bvl !== 1'b1 || nbl !== 1'(e) || pcl !== 1'b0)
          begin bad++; $display("FAIL lsb_w%0d_bit%0d: bv=%b nb=%b pc=%b exp bv=1 nb=%0d pc=0", n, i, bvl, nbl, pcl, e); end
        tick;
      end
      total++;
      if (pcl !== 1'b1 || bvl !== 1'b0 || nbl !== 1'b0)
        begin bad++; $display("FAIL lsb_final%0d: pc=%b bv=%b nb=%b exp 1 0 0", n, pcl, bvl, nbl); end
      tick;
      total++;
      if (pcl !== 1'b0 || pl !== 1'b1 || ol !== 1'b0)
        begin bad++; $display("FAIL lsb_idle%0d: pc=%b pr=%b oc=%b exp 0 1 0", n, pcl, pl, ol); end
    end
  endtask

  task automatic test_back_to_back;
    int ws [2] = '{4'hF, 4'h0};
    da = 4'hF; va = 1; tick;
    da = 4'h0;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 4; i++) begin
        int e = (ws[n] >> (3 - i)) & 1;
        total++;
        if (bva !== 1'b1 || nba !== 1'(e) || pa !== 1'b0)
          begin bad++; $display("FAIL b2b_w%0d_bit%0d: bv=%b nb=%b pr=%b exp bv=1 nb=%0d pr=0", n, i, bva, nba, pa, e); end
        tick;
      end
      total++;
      if (pca !== 1'b1 || bva !== 1'b0 || pa !== 1'b1)
        begin bad++; $display("FAIL b2b_final%0d: pc=%b bv=%b pr=%b exp 1 0 1", n, pca, bva, pa); end
      tick;
      va = 0;
    end
    total++;
    if (pca !== 1'b0 || bva !== 1'b0 || pa !== 1'b1)
      begin bad++; $display("FAIL b2b_idle: pc=%b bv=%b pr=%b exp 0 0 1", pca, bva, pa); end
  endtask

  task automatic test_busy_ignore;
    int w1 = 4'b0110;
    int w2 = 4'b1001;
    da = 4'(w1); va = 1; tick;
    va = 0;
    for (int i = 0; i < 4; i++) begin
      int e = (w1 >> (3 - i)) & 1;
      if (i == 1) begin da = 4'(w2); va = 1; end
      total++;
      if (bva !== 1'b1 || nba !== 1'(e) || pa !== 1'b0)
        begin bad++; $display("FAIL busy_bit%0d: bv=%b nb=%b pr=%b exp bv=1 nb=%0d pr=0", i, bva, nba, pa, e); end
      tick;
    end
    total++;
    if (pca !== 1'b1 || pa !== 1'b1)
      begin bad++; $display("FAIL busy_final: pc=%b pr=%b exp 1 1", pca, pa); end
    tick;
    va = 0;
    for (int i = 0; i < 4; i++) begin
      int e = (w2 >> (3 - i)) & 1;
      total++;
      if (bva !== 1'b1 || nba !== 1'(e))
        begin bad++; $display("FAIL busy_second_bit%0d: bv=%b nb=%b exp bv=1 nb=%0d", i, bva, nba, e); end
      tick;
    end
    total++;
    if (pca !== 1'b1 || sr !== 4'(w2))
      begin bad++; $display("FAIL busy_second_final: pc=%b sr=%b exp pc=1 sr=%b", pca, sr, 4'(w2)); end
    tick;
  endtask

  task automatic test_width8;
    for (int n = 0; n < 3; n++) begin
      int w = (n == 0) ? 8'hA5 : int'($urandom_range(0, 255));
      dw = 8'(w); vw = 1; tick;
      vw = 0; dw = 8'($urandom);
      for (int c = 1; c <= 8; c++) begin
        int e = (w >> (8 - c)) & 1;
        total++;
        if (bvw !== 1'b1 || nbw !== 1'(e) || pcw !== 1'b0 || ow !== 1'b1)
          begin bad++; $display("FAIL w8_w%0d_cycle%0d: bv=%b nb=%b pc=%b oc=%b exp 1 %0d 0 1", n, c, bvw, nbw, pcw, ow, e); end
        tick;
      end
      total++;
      if (pcw !== 1'b1 || bvw !== 1'b0 || pw !== 1'b1)
        begin bad++; $display("FAIL w8_cycle9_%0d: pc=%b bv=%b pr=%b exp 1 0 1", n, pcw, bvw, pw); end
      tick;
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 20; n++) begin
      int w = int'($urandom_range(0, 15));
      int gap;
      total++;
      if (pa !== 1'b1)
        begin bad++; $display("FAIL rand_ready%0d: got %b exp 1", n, pa); end
      da = 4'(w); va = 1; tick;
      for (int i = 0; i < 4; i++) begin
        int e = (w >> (3 - i)) & 1;
        da = 4'($urandom); va = 1'($urandom);
        total++;
        if (bva !== 1'b1 || nba !== 1'(e) || pca !== 1'b0 || pa !== 1'b0)
          begin bad++; $display("FAIL rand_w%0d_bit%0d: bv=%b nb=%b pc=%b pr=%b exp 1 %0d 0 0", n, i, bva, nba, pca, pa, e); end
        tick;
      end
      va = 0;
      total++;
      if (pca !== 1'b1 || bva !== 1'b0 || sr !== 4'(w))
        begin bad++; $display("FAIL rand_final%0d: pc=%b bv=%b sr=%b exp pc=1 bv=0 sr=%b", n, pca, bva, sr, 4'(w)); end
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tick;
        total++;
        if (pca !== 1'b0 || bva !== 1'b0 || pa !== 1'b1 || oa !== 1'b0)
          begin bad++; $display("FAIL rand_gap%0d: pc=%b bv=%b pr=%b oc=%b exp 0 0 1 0", n, pca, bva, pa, oa); end
      end
    end
    tick;
  endtask

  task automatic test_mid_reset;
    int w = 4'b1100;
    da = 4'(w); va = 1; tick;
    va = 0;
    for (int i = 0; i < 2; i++) begin
      int e = (w >> (3 - i)) & 1;
      total++;
      if (bva !== 1'b1 || nba !== 1'(e))
        begin bad++; $display("FAIL midrst_bit%0d: bv=%b nb=%b exp 1 %0d", i, bva, nba, e); end
      tick;
    end
    reset = 1'b1;
    #1;
    total++;
    if ({pa, nba, bva, pca, oa} !== 5'b0)
      begin bad++; $display("FAIL midrst_async: got %b exp 00000", {pa, nba, bva, pca, oa}); end
    tick;
    reset = 1'b0;
    #1;
    total++;
    if (pa !== 1'b1 || bva !== 1'b0)
      begin bad++; $display("FAIL midrst_release: pr=%b bv=%b exp 1 0", pa, bva); end
    for (int c = 0; c < 4; c++) begin
      tick;
      total++;
      if (pca !== 1'b0 || bva !== 1'b0 || oa !== 1'b0)
        begin bad++; $display("FAIL midrst_quiet%0d: pc=%b bv=%b oc=%b exp 0 0 0", c, pca, bva, oa); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_single_word;
    test_lsb_first;
    test_back_to_back;
    test_busy_ignore;
    test_width8;
    test_random;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
